// File: rtl/ctrlpim_pkg.sv
// Shared definitions for the PIM controller command path:
// op encodings, command field positions, dispatcher FSM states and the FIFO entry layout.
package ctrlpim_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_MAGIC = 2'b11
  } mmpu_op_e;

  localparam int CMD_W       = 34;
  localparam int CMD_OP_HI   = 33;
  localparam int CMD_OP_LO   = 32;
  localparam int CMD_DEST_HI = 31;
  localparam int CMD_DEST_LO = 22;
  localparam int CMD_SRC1_HI = 21;
  localparam int CMD_SRC1_LO = 12;
  localparam int CMD_SRC2_HI = 11;
  localparam int CMD_SRC2_LO = 2;
  localparam int CMD_COL_BIT = 1;

  // Crossbar range fields are stored at the command address width.
  localparam int ENTRY_ADDR_W = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } disp_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]        cmd;
    logic [ENTRY_ADDR_W-1:0] cstart;
    logic [ENTRY_ADDR_W-1:0] cend;
  } fifo_entry_t;

endpackage

// File: rtl/mmpu_cmd_fifo.sv
// Synchronous command FIFO with combinational head read; DEPTH must be a power of two, >= 2.
// Push is ignored when full, pop is ignored when empty; both may occur in one cycle.
module mmpu_cmd_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 54
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmpu_cmd_dispatch.sv
// Expands queued mMPU commands into one crossbar operation per crossbar in [cstart, cend].
// Optional performance counters are enabled by defining MMPU_DISPATCH_PERF_EN.
module mmpu_cmd_dispatch
  import ctrlpim_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int NUM_CROSSBAR = 64,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [33:0]       cmd,
  input  logic [ADDR_W-1:0] cmd_cstart,
  input  logic [ADDR_W-1:0] cmd_cend,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              busy,
  output logic              xbar_valid,
  input  logic              xbar_ready,
  output logic [ADDR_W-1:0] xbar_sel,
  output logic [1:0]        xbar_op,
  output logic [ADDR_W-1:0] xbar_dest,
  output logic [ADDR_W-1:0] xbar_src1,
  output logic [ADDR_W-1:0] xbar_src2,
  output logic              xbar_col
`ifdef MMPU_DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [ADDR_W-1:0] XB_MAX = ADDR_W'(NUM_CROSSBAR - 1);

  disp_state_e       state_r;
  disp_state_e       state_nxt_s;
  fifo_entry_t       wdata_s;
  fifo_entry_t       head_s;
  logic              pop_s;
  logic              load_s;
  logic              adv_s;
  logic              valid_nxt_s;
  logic              hs_s;
  logic              last_s;
  logic              head_nop_s;
  logic [ADDR_W-1:0] head_start_s;
  logic [ADDR_W-1:0] head_end_s;
  logic [ADDR_W-1:0] start_eff_s;
  logic [ADDR_W-1:0] end_eff_s;
  logic [ADDR_W-1:0] end_load_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] end_r;
  logic              valid_r;
  logic [1:0]        op_r;
  logic [ADDR_W-1:0] dest_r;
  logic [ADDR_W-1:0] src1_r;
  logic [ADDR_W-1:0] src2_r;
  logic              col_r;
  logic              unused_rsvd_s;

  // Pack the incoming command and its crossbar range into one FIFO entry.
  always_comb begin
    wdata_s        = '0;
    wdata_s.cmd    = cmd;
    wdata_s.cstart = ENTRY_ADDR_W'(cmd_cstart);
    wdata_s.cend   = ENTRY_ADDR_W'(cmd_cend);
  end

  mmpu_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .pop     (pop_s),
    .wdata   (wdata_s),
    .rdata   (head_s),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign unused_rsvd_s = head_s.cmd[0];
  assign head_nop_s    = (head_s.cmd[CMD_OP_HI:CMD_OP_LO] == OP_NOP);
  assign hs_s          = valid_r && xbar_ready;
  assign last_s        = (idx_r == end_r);
  assign busy          = (state_r != ST_IDLE) || !fifo_empty;

  // An inverted range collapses to a single operation at the clamped start.
  always_comb begin
    head_start_s = ADDR_W'(head_s.cstart);
    head_end_s   = ADDR_W'(head_s.cend);
    start_eff_s  = (head_start_s > XB_MAX) ? XB_MAX : head_start_s;
    end_eff_s    = (head_end_s > XB_MAX) ? XB_MAX : head_end_s;
    if (head_start_s > end_eff_s) begin
      end_load_s = start_eff_s;
    end else begin
      end_load_s = end_eff_s;
    end
  end

  // Next-state and pop/load decisions.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    adv_s       = 1'b0;
    valid_nxt_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        valid_nxt_s = 1'b0;
        if (!fifo_empty) begin
          pop_s = 1'b1;
          if (head_nop_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            load_s      = 1'b1;
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // First ISSUE cycle after IDLE only raises valid on the freshly loaded operands.
        if (!valid_r) begin
          valid_nxt_s = 1'b1;
        end else if (hs_s) begin
          if (!last_s) begin
            adv_s = 1'b1;
          end else if (!fifo_empty && !head_nop_s) begin
            pop_s  = 1'b1;
            load_s = 1'b1;
          end else if (!fifo_empty) begin
            pop_s       = 1'b1;
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
          end else begin
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          valid_nxt_s = valid_r;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, crossbar index and the registered operation presented to the array.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      idx_r   <= ADDR_W'(0);
      end_r   <= ADDR_W'(0);
      op_r    <= 2'b00;
      dest_r  <= ADDR_W'(0);
      src1_r  <= ADDR_W'(0);
      src2_r  <= ADDR_W'(0);
      col_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= valid_nxt_s;
      if (load_s) begin
        idx_r  <= start_eff_s;
        end_r  <= end_load_s;
        op_r   <= head_s.cmd[CMD_OP_HI:CMD_OP_LO];
        dest_r <= ADDR_W'(head_s.cmd[CMD_DEST_HI:CMD_DEST_LO]);
        src1_r <= ADDR_W'(head_s.cmd[CMD_SRC1_HI:CMD_SRC1_LO]);
        src2_r <= ADDR_W'(head_s.cmd[CMD_SRC2_HI:CMD_SRC2_LO]);
        col_r  <= head_s.cmd[CMD_COL_BIT];
      end else if (adv_s) begin
        idx_r <= idx_r + ADDR_W'(1);
      end
    end
  end

  assign xbar_valid = valid_r;
  assign xbar_sel   = idx_r;
  assign xbar_op    = op_r;
  assign xbar_dest  = dest_r;
  assign xbar_src1  = src1_r;
  assign xbar_src2  = src2_r;
  assign xbar_col   = col_r;

`ifdef MMPU_DISPATCH_PERF_EN
  logic [31:0] perf_issued_r;
  logic [31:0] perf_stall_r;

  // Saturating handshake and stall counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_issued_r <= 32'h0000_0000;
      perf_stall_r  <= 32'h0000_0000;
    end else begin
      if (hs_s && (perf_issued_r != 32'hFFFF_FFFF)) begin
        perf_issued_r <= perf_issued_r + 32'h0000_0001;
      end
      if (valid_r && !xbar_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'h0000_0001;
      end
    end
  end

  assign perf_issued = perf_issued_r;
  assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: tb/tb_mmpu_cmd_dispatch.sv
// Directed self-checking bench for mmpu_cmd_dispatch (default parameters).
module tb_mmpu_cmd_dispatch;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [33:0] cmd;
  logic [9:0]  cmd_cstart;
  logic [9:0]  cmd_cend;
  logic        fifo_full;
  logic        fifo_empty;
  logic        busy;
  logic        xbar_valid;
  logic        xbar_ready;
  logic [9:0]  xbar_sel;
  logic [1:0]  xbar_op;
  logic [9:0]  xbar_dest;
  logic [9:0]  xbar_src1;
  logic [9:0]  xbar_src2;
  logic        xbar_col;
`ifdef MMPU_DISPATCH_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int          n_pass;
  int          n_total;
  int          stall_err;
  logic [9:0]  hs_sel[$];
  logic [1:0]  hs_op[$];

  mmpu_cmd_dispatch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_cstart (cmd_cstart),
    .cmd_cend   (cmd_cend),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .busy       (busy),
    .xbar_valid (xbar_valid),
    .xbar_ready (xbar_ready),
    .xbar_sel   (xbar_sel),
    .xbar_op    (xbar_op),
    .xbar_dest  (xbar_dest),
    .xbar_src1  (xbar_src1),
    .xbar_src2  (xbar_src2),
    .xbar_col   (xbar_col)
`ifdef MMPU_DISPATCH_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [9:0] cs, input logic [9:0] ce);
    cmd        = {op, 10'h155, 10'h0AA, 10'h3C3, 1'b1, 1'b0};
    cmd_cstart = cs;
    cmd_cend   = ce;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  function automatic logic [43:0] snap();
    return {xbar_valid, xbar_sel, xbar_op, xbar_dest, xbar_src1, xbar_src2, xbar_col};
  endfunction

  // Drive xbar_ready from pat for ncyc cycles, logging handshakes and checking stall stability.
  task automatic collect(input int ncyc, input logic [31:0] pat);
    logic [43:0] prev;
    logic        prev_stall;
    hs_sel.delete();
    hs_op.delete();
    stall_err  = 0;
    prev       = 44'h0;
    prev_stall = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      xbar_ready = pat[c % 32];
      if (prev_stall && (snap() !== prev)) stall_err++;
      if (xbar_valid && xbar_ready) begin
        hs_sel.push_back(xbar_sel);
        hs_op.push_back(xbar_op);
      end
      prev_stall = xbar_valid && !xbar_ready;
      prev       = snap();
      tick();
    end
  endtask

  function automatic logic [9:0] sel_at(input int i);
    return (i < hs_sel.size()) ? hs_sel[i] : 10'h3FF;
  endfunction

  function automatic logic [1:0] op_at(input int i);
    return (i < hs_op.size()) ? hs_op[i] : 2'bxx;
  endfunction

  initial begin
    n_pass     = 0;
    n_total    = 0;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 34'h0;
    cmd_cstart = 10'd0;
    cmd_cend   = 10'd0;
    xbar_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", xbar_valid, 0);
    chk("rst_sel", xbar_sel, 0);

    // READ over crossbars 2..5 with ready held high
    xbar_ready = 1'b1;
    push(2'b01, 10'd2, 10'd5);
    chk("t1_busy_e", busy, 1);
    chk("t1_nempty_e", fifo_empty, 0);
    chk("t1_valid_e", xbar_valid, 0);
    tick();
    chk("t1_valid_e1", xbar_valid, 0);
    tick();
    chk("t1_valid_e2", xbar_valid, 1);
    chk("t1_sel0", xbar_sel, 2);
    chk("t1_op", xbar_op, 2'b01);
    chk("t1_dest", xbar_dest, 10'h155);
    chk("t1_src1", xbar_src1, 10'h0AA);
    chk("t1_src2", xbar_src2, 10'h3C3);
    chk("t1_col", xbar_col, 1);
    tick();
    chk("t1_sel1", xbar_sel, 3);
    tick();
    chk("t1_sel2", xbar_sel, 4);
    tick();
    chk("t1_sel3", xbar_sel, 5);
    chk("t1_valid_last", xbar_valid, 1);
    tick();
    chk("t1_valid_done", xbar_valid, 0);
    chk("t1_busy_done", busy, 0);

    // Two MAGIC commands back-to-back: 0..1 then 7..7 with no bubble
    push(2'b11, 10'd0, 10'd1);
    push(2'b11, 10'd7, 10'd7);
    tick();
    chk("t2_valid0", xbar_valid, 1);
    chk("t2_sel0", xbar_sel, 0);
    chk("t2_op", xbar_op, 2'b11);
    tick();
    chk("t2_sel1", xbar_sel, 1);
    tick();
    chk("t2_valid2", xbar_valid, 1);
    chk("t2_sel2", xbar_sel, 7);
    tick();
    chk("t2_valid_done", xbar_valid, 0);

    // Overflow: one command stalls in ISSUE, then 9 pushes into the 8-entry FIFO
    xbar_ready = 1'b0;
    push(2'b10, 10'd30, 10'd30);
    tick();
    tick();
    chk("t3_stall_valid", xbar_valid, 1);
    chk("t3_stall_sel", xbar_sel, 30);
    for (int k = 0; k < 8; k++) begin
      push(2'b10, 10'(10 + k), 10'(10 + k));
    end
    chk("t3_full8", fifo_full, 1);
    push(2'b10, 10'd18, 10'd18);
    chk("t3_full9", fifo_full, 1);
    chk("t3_hold_valid", xbar_valid, 1);
    chk("t3_hold_sel", xbar_sel, 30);
    collect(20, 32'hFFFF_FFFF);
    chk("t3_count", hs_sel.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk("t3_sel", sel_at(i), (i == 0) ? 32'd30 : 32'(10 + i - 1));
    end
    chk("t3_empty", fifo_empty, 1);

    // Range clamp (70..80 -> 63) and inverted range (9..3 -> 9)
    xbar_ready = 1'b1;
    push(2'b01, 10'd70, 10'd80);
    push(2'b01, 10'd9, 10'd3);
    collect(10, 32'hFFFF_FFFF);
    chk("t4_count", hs_sel.size(), 2);
    chk("t4_sel0", sel_at(0), 63);
    chk("t4_sel1", sel_at(1), 9);

    // WRITE 20..21, NOP, WRITE 40 under an irregular ready pattern
    xbar_ready = 1'b0;
    push(2'b10, 10'd20, 10'd21);
    push(2'b00, 10'd50, 10'd50);
    push(2'b10, 10'd40, 10'd40);
    collect(30, 32'hB6D2_CB4D);
    chk("t5_count", hs_sel.size(), 3);
    chk("t5_sel0", sel_at(0), 20);
    chk("t5_sel1", sel_at(1), 21);
    chk("t5_sel2", sel_at(2), 40);
    for (int i = 0; i < 3; i++) begin
      chk("t5_op", op_at(i), 2'b10);
    end
    chk("t5_stall_stable", stall_err, 0);
    chk("t5_busy_done", busy, 0);

    // Reset at the 3rd of 5 operations, with a second command queued
    xbar_ready = 1'b1;
    push(2'b01, 10'd0, 10'd4);
    push(2'b10, 10'd50, 10'd50);
    tick();
    chk("t6_sel0", xbar_sel, 0);
    tick();
    tick();
    chk("t6_sel2", xbar_sel, 2);
    reset_n = 1'b0;
    tick();
    chk("t6_valid", xbar_valid, 0);
    chk("t6_empty", fifo_empty, 1);
    chk("t6_busy", busy, 0);
    reset_n = 1'b1;
    collect(10, 32'hFFFF_FFFF);
    chk("t6_no_issue", hs_sel.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
